// File: rtl/wb_bridge_pkg.sv
// Shared types and sizing helpers for the registered Wishbone slave bridge.
// The optional watchdog is enabled with the WB_BRIDGE_TIMEOUT_EN macro.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
    localparam int unsigned TO_CNT_W           = $clog2(DEF_TIMEOUT_CYCLES);

    // Counter width for a given watchdog length; never narrower than one bit.
    function automatic int unsigned to_cnt_w(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/wb_bridge_watchdog.sv
// Wait-state counter for the bridge; flags expiry on the last allowed S_WAIT cycle.
// Only instantiated when WB_BRIDGE_TIMEOUT_EN is defined.
module wb_bridge_watchdog
    import wb_bridge_pkg::*;
#(
    parameter int unsigned TimeoutCycles = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CntW          = TO_CNT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic waiting_i,
    output logic expired_o
);

    localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Held at zero outside S_WAIT, so the first wait cycle always sees a count of zero.
    always_comb begin
        cnt_d = '0;
        if (waiting_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = waiting_i && (cnt_q == LastCnt);

endmodule

// File: rtl/wishbone_slave_bridge.sv
// Registered request/response slice between a classic Wishbone master port and one slave.
// Define WB_BRIDGE_TIMEOUT_EN to add a watchdog that ends transfers the slave never acks.
module wishbone_slave_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    // upstream (arbitrator side)
    input  logic                      m_we_o,
    input  logic                      m_stb_o,
    input  logic                      m_cyc_o,
    input  logic [DATA_WIDTH/8-1:0]   m_sel_o,
    input  logic [ADDR_WIDTH-1:0]     m_adr_o,
    input  logic [DATA_WIDTH-1:0]     m_dat_o,
    output logic [DATA_WIDTH-1:0]     m_dat_i,
    output logic                      m_ack_i,
    output logic                      m_int_i,
    // downstream (slave side)
    output logic                      s_we_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic [DATA_WIDTH/8-1:0]   s_sel_o,
    output logic [ADDR_WIDTH-1:0]     s_adr_o,
    output logic [DATA_WIDTH-1:0]     s_dat_o,
    input  logic                      s_ack_i,
    input  logic [DATA_WIDTH-1:0]     s_dat_i,
    input  logic                      s_int_i,
    output logic                      timeout_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e                    state_q, state_d;
    logic                      we_q, we_d;
    logic [DATA_WIDTH/8-1:0]   sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]     adr_q, adr_d;
    logic [DATA_WIDTH-1:0]     wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]     rdat_q, rdat_d;
    logic                      int_q;
    logic                      timeout_hit;

`ifdef WB_BRIDGE_TIMEOUT_EN
    logic wd_expired;
    logic timeout_q;

    wb_bridge_watchdog #(
        .TimeoutCycles (TIMEOUT_CYCLES),
        .CntW          (to_cnt_w(TIMEOUT_CYCLES))
    ) u_watchdog (
        .clk_i     (clk),
        .rst_ni    (rst),
        .waiting_i (state_q == S_WAIT),
        .expired_o (wd_expired)
    );

    // Abort and a same-cycle ack both take precedence over expiry.
    assign timeout_hit = (state_q == S_WAIT) && m_cyc_o && !s_ack_i && wd_expired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;

        case (state_q)
            S_IDLE: begin
                if (m_cyc_o && m_stb_o) begin
                    we_d    = m_we_o;
                    sel_d   = m_sel_o;
                    adr_d   = m_adr_o;
                    wdat_d  = m_dat_o;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!m_cyc_o) begin
                    state_d = S_IDLE;
                end else if (s_ack_i) begin
                    rdat_d  = s_dat_i;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    rdat_d  = TIMEOUT_DATA;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            int_q   <= s_int_i;
        end
    end

    // Strobe/cycle and ack are pure decodes of the state register, so both stay glitch-free.
    assign s_cyc_o = (state_q == S_WAIT);
    assign s_stb_o = (state_q == S_WAIT);
    assign s_we_o  = we_q;
    assign s_sel_o = sel_q;
    assign s_adr_o = adr_q;
    assign s_dat_o = wdat_q;
    assign m_ack_i = (state_q == S_RESP);
    assign m_dat_i = rdat_q;
    assign m_int_i = int_q;

endmodule

// File: tb/tb_wishbone_slave_bridge.sv
// Directed, table-driven bench for wishbone_slave_bridge (timeout checks follow WB_BRIDGE_TIMEOUT_EN).
module tb_wishbone_slave_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_we_o, m_stb_o, m_cyc_o;
    logic [3:0]    m_sel_o;
    logic [AW-1:0] m_adr_o;
    logic [DW-1:0] m_dat_o;
    logic [DW-1:0] m_dat_i;
    logic          m_ack_i, m_int_i;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic [3:0]    s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_ack_i;
    logic [DW-1:0] s_dat_i;
    logic          s_int_i;
    logic          timeout_o;

    wishbone_slave_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_we_o    (m_we_o),
        .m_stb_o   (m_stb_o),
        .m_cyc_o   (m_cyc_o),
        .m_sel_o   (m_sel_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_ack_i   (m_ack_i),
        .m_int_i   (m_int_i),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_sel_o   (s_sel_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_ack_i   (s_ack_i),
        .s_dat_i   (s_dat_i),
        .s_int_i   (s_int_i),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] last_dat;

    typedef struct {
        logic          we;
        logic [3:0]    sel;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdat;
        int            delay;
        logic [DW-1:0] rdat;
        logic [DW-1:0] exp_dat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_master;
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_sel_o = '0;
        m_adr_o = '0;
        m_dat_o = '0;
    endtask

    task automatic run_vec(input vec_t v);
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = v.we;
        m_sel_o = v.sel;
        m_adr_o = v.adr;
        m_dat_o = v.wdat;
        tick;
        chk("req_stb", s_stb_o, 1);
        chk("req_cyc", s_cyc_o, 1);
        chk("req_adr", s_adr_o, v.adr);
        chk("req_we", s_we_o, v.we);
        chk("req_sel", s_sel_o, v.sel);
        chk("req_dat", s_dat_o, v.wdat);
        chk("req_noack", m_ack_i, 0);
        // upstream changes while waiting must not leak through
        m_we_o  = ~v.we;
        m_sel_o = ~v.sel;
        m_adr_o = ~v.adr;
        m_dat_o = ~v.wdat;
        for (int i = 0; i < v.delay; i++) begin
            tick;
            chk("hold_adr", s_adr_o, v.adr);
            chk("hold_dat", s_dat_o, v.wdat);
            chk("hold_stb", s_stb_o, 1);
            chk("wait_noack", m_ack_i, 0);
            chk("wait_mdat", m_dat_i, last_dat);
        end
        s_ack_i = 1'b1;
        s_dat_i = v.rdat;
        tick;
        s_ack_i = 1'b0;
        s_dat_i = 32'h0BAD_0BAD;
        chk("resp_ack", m_ack_i, 1);
        chk("resp_dat", m_dat_i, v.exp_dat);
        chk("resp_stb", s_stb_o, 0);
        last_dat = v.exp_dat;
        idle_master();
        tick;
        chk("post_ack", m_ack_i, 0);
        chk("post_dat", m_dat_i, last_dat);
    endtask

    initial begin
        int  n;
        logic seen_ack;

        vecs[0] = '{we: 1'b0, sel: 4'hF, adr: 32'h0000_0100, wdat: 32'h0,
                    delay: 2, rdat: 32'hCAFE_F00D, exp_dat: 32'hCAFE_F00D};
        vecs[1] = '{we: 1'b1, sel: 4'b0011, adr: 32'h0000_0008, wdat: 32'h1234_5678,
                    delay: 3, rdat: 32'hDEAD_BEEF, exp_dat: 32'hDEAD_BEEF};
        vecs[2] = '{we: 1'b0, sel: 4'b1000, adr: 32'h0000_003C, wdat: 32'h0,
                    delay: 0, rdat: 32'h0000_00A5, exp_dat: 32'h0000_00A5};
        vecs[3] = '{we: 1'b1, sel: 4'hF, adr: 32'hFFFF_FFFC, wdat: 32'hA5A5_5A5A,
                    delay: 1, rdat: 32'h0000_0001, exp_dat: 32'h0000_0001};
        // ack lands exactly on the watchdog's last cycle: ack must win
        vecs[4] = '{we: 1'b0, sel: 4'hF, adr: 32'h0000_0040, wdat: 32'h0,
                    delay: TO - 1, rdat: 32'h5555_AAAA, exp_dat: 32'h5555_AAAA};

        rst      = 1'b0;
        idle_master();
        s_ack_i  = 1'b0;
        s_dat_i  = '0;
        s_int_i  = 1'b0;
        last_dat = '0;
        tick;
        tick;
        chk("rst_stb", s_stb_o, 0);
        chk("rst_cyc", s_cyc_o, 0);
        chk("rst_ack", m_ack_i, 0);
        chk("rst_mdat", m_dat_i, 0);
        chk("rst_timeout", timeout_o, 0);
        rst = 1'b1;
        tick;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end
        chk("ack_beats_expiry", timeout_o, 0);

        // back-to-back reads with strobe held high
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_sel_o = 4'hF;
        m_adr_o = 32'h0;
        tick;
        chk("b2b_adr0", s_adr_o, 32'h0);
        s_ack_i = 1'b1;
        s_dat_i = 32'h1111_0000;
        tick;
        s_ack_i = 1'b0;
        chk("b2b_ack0", m_ack_i, 1);
        chk("b2b_dat0", m_dat_i, 32'h1111_0000);
        m_adr_o = 32'h4;
        tick;
        chk("b2b_idle_stb", s_stb_o, 0);
        chk("b2b_idle_ack", m_ack_i, 0);
        tick;
        chk("b2b_stb1", s_stb_o, 1);
        chk("b2b_adr1", s_adr_o, 32'h4);
        s_ack_i = 1'b1;
        s_dat_i = 32'h2222_0004;
        tick;
        s_ack_i = 1'b0;
        chk("b2b_ack1", m_ack_i, 1);
        chk("b2b_dat1", m_dat_i, 32'h2222_0004);
        last_dat = 32'h2222_0004;
        idle_master();
        tick;

        // abort while waiting, then a late ack
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_adr_o = 32'h200;
        tick;
        tick;
        chk("abort_pre_stb", s_stb_o, 1);
        m_cyc_o = 1'b0;
        tick;
        chk("abort_cyc", s_cyc_o, 0);
        chk("abort_stb", s_stb_o, 0);
        chk("abort_noack", m_ack_i, 0);
        m_stb_o = 1'b0;
        s_ack_i = 1'b1;
        s_dat_i = 32'h00BA_DBAD;
        tick;
        chk("late_ack_ign", m_ack_i, 0);
        chk("late_ack_dat", m_dat_i, last_dat);
        s_ack_i = 1'b0;
        tick;

        // abort and ack in the same cycle: abort wins
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_adr_o = 32'h300;
        tick;
        m_cyc_o = 1'b0;
        s_ack_i = 1'b1;
        s_dat_i = 32'h7777_7777;
        tick;
        s_ack_i = 1'b0;
        chk("abort_prio_ack", m_ack_i, 0);
        chk("abort_prio_stb", s_stb_o, 0);
        chk("abort_prio_dat", m_dat_i, last_dat);
        idle_master();
        tick;
        chk("abort_prio_ack2", m_ack_i, 0);

        // interrupt is a one-cycle delay of the slave line
        s_int_i = 1'b1;
        chk("int_not_comb", m_int_i, 0);
        tick;
        chk("int_rise", m_int_i, 1);
        s_int_i = 1'b0;
        tick;
        chk("int_fall", m_int_i, 0);

        // slave that never acks
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_adr_o = 32'h400;
        tick;
        chk("to_pre_flag", timeout_o, 0);
`ifdef WB_BRIDGE_TIMEOUT_EN
        n = 0;
        while (!m_ack_i && n < 40) begin
            tick;
            n++;
        end
        chk("to_wait_cycles", n, TO);
        chk("to_ack", m_ack_i, 1);
        chk("to_dat", m_dat_i, 32'hFFFF_FFFF);
        chk("to_flag", timeout_o, 1);
        last_dat = 32'hFFFF_FFFF;
        idle_master();
        tick;
        chk("to_ack_pulse", m_ack_i, 0);
        tick;
        chk("to_sticky", timeout_o, 1);
`else
        seen_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (m_ack_i) seen_ack = 1'b1;
        end
        chk("noto_ack", seen_ack, 0);
        chk("noto_stb", s_stb_o, 1);
        chk("noto_flag", timeout_o, 0);
        idle_master();
        tick;
`endif

        // asynchronous reset in the middle of a transfer
        s_int_i = 1'b1;
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_sel_o = 4'hA;
        m_adr_o = 32'h0000_0ABC;
        m_dat_o = 32'h9999_8888;
        tick;
        chk("mid_pre_stb", s_stb_o, 1);
        chk("mid_pre_int", m_int_i, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_stb", s_stb_o, 0);
        chk("mid_rst_cyc", s_cyc_o, 0);
        chk("mid_rst_adr", s_adr_o, 0);
        chk("mid_rst_we", s_we_o, 0);
        chk("mid_rst_sel", s_sel_o, 0);
        chk("mid_rst_sdat", s_dat_o, 0);
        chk("mid_rst_mdat", m_dat_i, 0);
        chk("mid_rst_ack", m_ack_i, 0);
        chk("mid_rst_int", m_int_i, 0);
        chk("mid_rst_to", timeout_o, 0);
        idle_master();
        s_int_i  = 1'b0;
        last_dat = '0;
        tick;
        rst = 1'b1;
        tick;
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
